// File: rtl/note_tone_gen.sv
// note_tone_gen: enveloped square-wave sample generator with a valid/ready output.
// With NOTE_TONE_ENVELOPE_EN defined, amplitude ramps through ATTACK/SUSTAIN/RELEASE.
// Otherwise, note-on or note-off switches amplitude straight between 0 and PEAK at a tick.
module note_tone_gen #(
    parameter int SAMPLE_DIV = 1042,
    parameter int AMP_W = 16,
    parameter logic [AMP_W-1:0] PEAK = 16'h3FFF,
    parameter logic [AMP_W-1:0] STEP = 16'h0100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      freq,
    input  logic             sample_ready,
    output logic             sample_valid,
    output logic [AMP_W-1:0] sample,
    output logic             active,
    output logic             overrun
);
    localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
`ifdef NOTE_TONE_ENVELOPE_EN
    typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SUSTAIN} state_t;
`endif
    state_t state, state_nxt;
    logic [DW-1:0] div_cnt;
    logic tick, hp_wrap, in_release, polarity;
    logic [31:0] hp_cnt, freq_q;
    logic [AMP_W-1:0] amp, amp_nxt;
    assign tick = div_cnt == DW'(SAMPLE_DIV - 1);
    assign hp_wrap = hp_cnt == freq_q - 32'd1;
    assign active = state != IDLE;
    // sample-rate divider producing one tick per SAMPLE_DIV cycles
    always_ff @(posedge clk) begin
        if (reset) div_cnt <= '0;
        else div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end
    // half-period oscillator; a new pitch is adopted only at a polarity flip
    always_ff @(posedge clk) begin
        if (reset) begin
            hp_cnt <= '0;
            polarity <= 1'b0;
            freq_q <= '0;
        end else if (freq_q == '0) begin
            hp_cnt <= '0;
            freq_q <= freq;
        end else if (hp_wrap) begin
            hp_cnt <= '0;
            polarity <= ~polarity;
            freq_q <= (in_release && freq == '0) ? freq_q : freq;
        end else begin
            hp_cnt <= hp_cnt + 32'd1;
        end
    end
`ifdef NOTE_TONE_ENVELOPE_EN
    logic [AMP_W:0] amp_up, amp_dn;
    assign amp_up = {1'b0, amp} + {1'b0, STEP};
    assign amp_dn = {1'b0, amp} - {1'b0, STEP};
    // envelope next state and saturating amplitude ramp (ramp moves only on tick)
    always_comb begin
        state_nxt = state;
        amp_nxt = amp;
        in_release = 1'b0;
        case (state)
            IDLE: begin
                amp_nxt = '0;
                state_nxt = (freq != '0) ? ATTACK : IDLE;
            end
            ATTACK: begin
                amp_nxt = tick ? ((amp_up > {1'b0, PEAK}) ? PEAK : amp_up[AMP_W-1:0]) : amp;
                state_nxt = (freq == '0) ? RELEASE : (amp == PEAK) ? SUSTAIN : ATTACK;
            end
            SUSTAIN: begin
                amp_nxt = PEAK;
                state_nxt = (freq == '0) ? RELEASE : SUSTAIN;
            end
            RELEASE: begin
                in_release = 1'b1;
                amp_nxt = tick ? (amp_dn[AMP_W] ? '0 : amp_dn[AMP_W-1:0]) : amp;
                state_nxt = (freq != '0) ? ATTACK : (amp == '0) ? IDLE : RELEASE;
            end
        endcase
    end
`else
    // gate amplitude between 0 and PEAK at each tick
    always_comb begin
        in_release = 1'b0;
        amp_nxt = tick ? ((freq != '0) ? PEAK : '0) : amp;
        state_nxt = tick ? ((freq != '0) ? SUSTAIN : IDLE) : state;
    end
`endif
    // envelope state and amplitude registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            amp <= '0;
        end else begin
            state <= state_nxt;
            amp <= amp_nxt;
        end
    end
    // output sample register, valid/ready handshake and sticky overrun flag
    always_ff @(posedge clk) begin
        if (reset) begin
            sample <= '0;
            sample_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (tick) begin
                sample <= polarity ? -amp_nxt : amp_nxt;
                sample_valid <= 1'b1;
            end else if (sample_ready) begin
                sample_valid <= 1'b0;
            end
            if (tick && sample_valid && !sample_ready) overrun <= 1'b1;
        end
    end
endmodule
